// File: rtl/sequential_divider.sv
// Signed restoring shift-subtract divider, one quotient bit per clock.
// Truncating semantics: quotient toward zero, remainder follows dividend sign.
module sequential_divider #(
    parameter int Word_Length = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start,
    input  logic [Word_Length-1:0] Dividend_Input,
    input  logic [Word_Length-1:0] Divisor_Input,
    output logic [Word_Length-1:0] Quotient,
    output logic [Word_Length-1:0] Remainder,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Div_By_Zero,
    output logic                   Overflow
);

    localparam int W  = Word_Length;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIX,
        DONE
    } state_t;

    state_t         state;
    logic [W:0]     part_rem;
    logic [W-1:0]   quo_reg;
    logic [W-1:0]   dsr_mag;
    logic [W-1:0]   dvd_raw;
    logic [CW-1:0]  cnt;
    logic           sign_q;
    logic           sign_r;
    logic           div0;
    logic           ovf;

    logic [W-1:0]   dvd_mag_in;
    logic [W-1:0]   dsr_mag_in;
    logic [W+1:0]   shifted;
    logic [W+1:0]   trial;
    logic           ge;
    logic [W-1:0]   min_val;

    // Operand magnitudes and the trial subtraction for the current step
    always_comb begin
        min_val    = {1'b1, {(W-1){1'b0}}};
        dvd_mag_in = Dividend_Input[W-1] ? -Dividend_Input : Dividend_Input;
        dsr_mag_in = Divisor_Input[W-1]  ? -Divisor_Input  : Divisor_Input;
        shifted    = {part_rem, quo_reg[W-1]};
        trial      = shifted - {2'b00, dsr_mag};
        ge         = ~trial[W+1];
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            part_rem    <= '0;
            quo_reg     <= '0;
            dsr_mag     <= '0;
            dvd_raw     <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            div0        <= 1'b0;
            ovf         <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Div_By_Zero <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    Busy <= Start;
                    if (Start) begin
                        part_rem <= '0;
                        quo_reg  <= dvd_mag_in;
                        dsr_mag  <= dsr_mag_in;
                        dvd_raw  <= Dividend_Input;
                        cnt      <= CW'(W);
                        sign_q   <= Dividend_Input[W-1] ^ Divisor_Input[W-1];
                        sign_r   <= Dividend_Input[W-1];
                        div0     <= (Divisor_Input == '0);
                        ovf      <= (Dividend_Input == min_val)
                                    && (&Divisor_Input);
                        state    <= (Divisor_Input == '0) ? FIX : DIVIDE;
                    end
                end
                DIVIDE: begin
                    part_rem <= ge ? trial[W:0] : shifted[W:0];
                    quo_reg  <= {quo_reg[W-2:0], ge};
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div0) begin
                        Quotient    <= '1;
                        Remainder   <= dvd_raw;
                        Div_By_Zero <= 1'b1;
                        Overflow    <= 1'b0;
                    end else if (ovf) begin
                        Quotient    <= min_val;
                        Remainder   <= '0;
                        Div_By_Zero <= 1'b0;
                        Overflow    <= 1'b1;
                    end else begin
                        Quotient    <= sign_q ? -quo_reg : quo_reg;
                        Remainder   <= sign_r ? -part_rem[W-1:0]
                                              : part_rem[W-1:0];
                        Div_By_Zero <= 1'b0;
                        Overflow    <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (8-bit).
// Hand-computed quotient/remainder/flags and Done latency per vector.
module tb_sequential_divider;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] Dividend_Input = '0;
    logic [7:0] Divisor_Input = '0;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       Div_By_Zero;
    logic       Overflow;

    int total = 0;
    int bad   = 0;

    sequential_divider #(.Word_Length(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .Start         (Start),
        .Dividend_Input(Dividend_Input),
        .Divisor_Input (Divisor_Input),
        .Quotient      (Quotient),
        .Remainder     (Remainder),
        .Busy          (Busy),
        .Done          (Done),
        .Div_By_Zero   (Div_By_Zero),
        .Overflow      (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] q,
                       input logic [7:0] r, input logic dz,
                       input logic ov, input int lat, input bit inject);
        int n;
        int dones;
        @(negedge clk);
        Dividend_Input = a;
        Divisor_Input  = b;
        Start          = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (Done || n >= 40) break;
            if (inject && n == 3) begin
                Start          = 1'b1;
                Dividend_Input = 8'd50;
                Divisor_Input  = 8'd3;
            end
            if (inject && n == 4) Start = 1'b0;
            @(posedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_done"}, Done, 1);
        chk({tag, "_busy"}, Busy, 1);
        chk({tag, "_q"}, Quotient, q);
        chk({tag, "_r"}, Remainder, r);
        chk({tag, "_dz"}, Div_By_Zero, dz);
        chk({tag, "_ov"}, Overflow, ov);
        @(negedge clk);
        chk({tag, "_done_drop"}, Done, 0);
        chk({tag, "_busy_drop"}, Busy, 0);
        if (inject) begin
            dones = 0;
            repeat (14) begin
                @(negedge clk);
                if (Done) dones++;
            end
            chk({tag, "_extra_done"}, dones, 0);
            chk({tag, "_q_hold"}, Quotient, q);
            chk({tag, "_r_hold"}, Remainder, r);
        end
    endtask

    initial begin
        int dones;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs",
            {Quotient, Remainder, Busy, Done, Div_By_Zero, Overflow}, 0);
        reset = 1'b1;

        run("p_p",   8'd100, 8'd7,   8'h0E, 8'h02, 0, 0, 10, 0);
        run("n_p",   8'h9C,  8'd7,   8'hF2, 8'hFE, 0, 0, 10, 0);
        run("p_n",   8'd100, 8'hF9,  8'hF2, 8'h02, 0, 0, 10, 0);
        run("n_n",   8'h9C,  8'hF9,  8'h0E, 8'hFE, 0, 0, 10, 0);
        run("dz",    8'd25,  8'd0,   8'hFF, 8'h19, 1, 0, 2,  0);
        run("ovf",   8'h80,  8'hFF,  8'h80, 8'h00, 0, 1, 10, 0);
        run("min1",  8'h80,  8'h01,  8'h80, 8'h00, 0, 0, 10, 0);
        run("busy",  8'd100, 8'd7,   8'h0E, 8'h02, 0, 0, 10, 1);
        run("small", 8'd5,   8'd9,   8'h00, 8'h05, 0, 0, 10, 0);

        @(negedge clk);
        Dividend_Input = 8'd100;
        Divisor_Input  = 8'd7;
        Start          = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_outs",
            {Quotient, Remainder, Busy, Done, Div_By_Zero, Overflow}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (14) begin
            @(negedge clk);
            if (Done || Busy) dones++;
        end
        chk("abort_no_done", dones, 0);

        run("after_rst", 8'd9, 8'd3, 8'h03, 8'h00, 0, 0, 10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
